locked_prio_irq_ctrl: RTL and testbench

- Parametrised, clocked successor to the combinational key-locked 27-channel priority interrupt controller used in the SAT-attack benchmarks.
- Takes NUM_BUSES request buses of BUS_WIDTH channels each (fixed bus priority, bus 0 highest; within a bus, lowest index highest) and arbitrates them behind a serially loaded key.
- Issues one registered grant at a time under a valid/ack handshake.
- Key gates (XOR/XNOR against the loaded key) sit on internal request nets and on the grant encoding; functionally correct only when the loaded key equals KEY_PATTERN.

---
 rtl/locked_prio_irq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_locked_prio_irq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/locked_prio_irq_ctrl.sv
// locked_prio_irq_ctrl: key-locked multi-bus priority interrupt controller.
// Optional macro LOCKED_IRQ_STICKY_REQ_EN holds requests pending until granted.
module locked_prio_irq_ctrl #(
    parameter int NUM_BUSES = 3,
    parameter int BUS_WIDTH = 9,
    parameter int KEY_WIDTH = 32,
    parameter logic [KEY_WIDTH-1:0] KEY_PATTERN = 32'hA5C3_0F96,
    localparam int CW = ($clog2(BUS_WIDTH) > 1) ? $clog2(BUS_WIDTH) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           key_load,
    input  logic                           key_sdi,
    input  logic [NUM_BUSES*BUS_WIDTH-1:0] req,
    input  logic [BUS_WIDTH-1:0]           chan_en,
    input  logic                           grant_ack,
    output logic                           key_ready,
    output logic                           grant_valid,
    output logic [NUM_BUSES-1:0]           grant_bus,
    output logic [CW-1:0]                  grant_chan
);

    localparam int N    = NUM_BUSES * BUS_WIDTH;
    localparam int CNTW = $clog2(KEY_WIDTH + 1);

    typedef enum logic [1:0] {
        S_LOCKED,
        S_LOAD,
        S_IDLE,
        S_HOLD
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [KEY_WIDTH-1:0] key;
    logic [CNTW-1:0]     cnt;
    logic [CNTW-1:0]     cnt_nx;
    logic                shift;
    logic                enter_load;
    logic                load_grant;
    logic                clr_valid;
    logic [N-1:0]        r;
    logic [N-1:0]        cand;
    logic                hit;
    logic [NUM_BUSES-1:0] win_bus;
    logic [CW-1:0]       win_idx;
    logic [CW-1:0]       chan_enc;

    // Key gates on the request nets: transparent only when key == KEY_PATTERN.
    for (genvar j = 0; j < N; j++) begin : g_req
        assign r[j] = (req[j] & chan_en[j % BUS_WIDTH])
                    ^ key[j % KEY_WIDTH] ^ KEY_PATTERN[j % KEY_WIDTH];
    end

    // Key gates on the grant encoding, taken from the top of the key.
    for (genvar c = 0; c < CW; c++) begin : g_chan
        assign chan_enc[c] = win_idx[c]
                           ^ key[KEY_WIDTH-1-(c % KEY_WIDTH)]
                           ^ KEY_PATTERN[KEY_WIDTH-1-(c % KEY_WIDTH)];
    end

`ifdef LOCKED_IRQ_STICKY_REQ_EN
    logic [N-1:0] pending;
    logic [N-1:0] win_mask;

    assign cand = pending | r;

    // Accumulate requests while running; drop the granted one on grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (enter_load) begin
            pending <= '0;
        end else if (key_ready) begin
            pending <= cand & ~(load_grant ? win_mask : '0);
        end
    end
`else
    assign cand = r;
`endif

    // Fixed priority: lowest flat index wins (bus 0 first, then channel).
    always_comb begin
        hit     = 1'b0;
        win_bus = '0;
        win_idx = '0;
`ifdef LOCKED_IRQ_STICKY_REQ_EN
        win_mask = '0;
`endif
        for (int b = NUM_BUSES - 1; b >= 0; b--) begin
            for (int c = BUS_WIDTH - 1; c >= 0; c--) begin
                if (cand[b*BUS_WIDTH+c]) begin
                    hit        = 1'b1;
                    win_bus    = '0;
                    win_bus[b] = 1'b1;
                    win_idx    = CW'(c);
`ifdef LOCKED_IRQ_STICKY_REQ_EN
                    win_mask   = '0;
                    win_mask[b*BUS_WIDTH+c] = 1'b1;
`endif
                end
            end
        end
    end

    // Next-state and control decode; key_load has priority over grant_ack.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        shift      = 1'b0;
        enter_load = 1'b0;
        load_grant = 1'b0;
        clr_valid  = 1'b0;
        unique case (state)
            S_LOCKED: begin
                if (key_load) begin
                    state_nx   = S_LOAD;
                    shift      = 1'b1;
                    enter_load = 1'b1;
                    cnt_nx     = CNTW'(1);
                end
            end
            S_LOAD: begin
                if (key_load) begin
                    shift = 1'b1;
                    if (cnt != CNTW'(KEY_WIDTH)) cnt_nx = cnt + CNTW'(1);
                end else if (cnt == CNTW'(KEY_WIDTH)) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_LOCKED;
                    cnt_nx   = '0;
                end
            end
            S_IDLE, S_HOLD: begin
                if (key_load) begin
                    state_nx   = S_LOAD;
                    shift      = 1'b1;
                    enter_load = 1'b1;
                    clr_valid  = 1'b1;
                    cnt_nx     = CNTW'(1);
                end else if (state == S_IDLE) begin
                    if (hit) begin
                        load_grant = 1'b1;
                        state_nx   = S_HOLD;
                    end
                end else if (grant_ack) begin
                    clr_valid = 1'b1;
                    state_nx  = S_IDLE;
                end
            end
            default: state_nx = S_LOCKED;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_LOCKED;
        else     state <= state_nx;
    end

    // Key shifter, bit counter and registered grant outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key         <= '0;
            cnt         <= '0;
            grant_valid <= 1'b0;
            grant_bus   <= '0;
            grant_chan  <= '0;
        end else begin
            cnt <= cnt_nx;
            if (shift) key <= {key_sdi, key[KEY_WIDTH-1:1]};
            if (load_grant) begin
                grant_valid <= 1'b1;
                grant_bus   <= win_bus;
                grant_chan  <= chan_enc;
            end else if (clr_valid) begin
                grant_valid <= 1'b0;
            end
        end
    end

    assign key_ready = (state == S_IDLE) || (state == S_HOLD);

endmodule

// File: tb/tb_locked_prio_irq_ctrl.sv
// tb_locked_prio_irq_ctrl: directed + random bench with a reference model.
// Model tracks key history, load progress and the outstanding grant.
module tb_locked_prio_irq_ctrl;

    localparam int NB = 3;
    localparam int BW = 9;
    localparam int KW = 32;
    localparam int N  = 27;
    localparam int CW = 4;
    localparam logic [31:0] KP = 32'hA5C3_0F96;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_load = 1'b0;
    logic          key_sdi = 1'b0;
    logic          grant_ack = 1'b0;
    logic [N-1:0]  req = '0;
    logic [BW-1:0] chan_en = '1;
    logic          key_ready;
    logic          grant_valid;
    logic [NB-1:0] grant_bus;
    logic [CW-1:0] grant_chan;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] m_key;
    int          m_cnt;
    bit          m_loading;
    bit          m_ready;
    bit          m_gv;
    logic [2:0]  m_gb;
    logic [3:0]  m_gc;
`ifdef LOCKED_IRQ_STICKY_REQ_EN
    logic [N-1:0] m_pend;
`endif

    always #5 clk = ~clk;

    locked_prio_irq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .key_sdi    (key_sdi),
        .req        (req),
        .chan_en    (chan_en),
        .grant_ack  (grant_ack),
        .key_ready  (key_ready),
        .grant_valid(grant_valid),
        .grant_bus  (grant_bus),
        .grant_chan (grant_chan)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".key_ready"}, 32'(key_ready), 32'(m_ready));
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(m_gv));
        chk({tag, ".grant_bus"}, 32'(grant_bus), 32'(m_gb));
        chk({tag, ".grant_chan"}, 32'(grant_chan), 32'(m_gc));
    endtask

    function automatic logic [N-1:0] eff_req(input logic [31:0] k);
        logic [N-1:0] e;
        for (int j = 0; j < N; j++)
            e[j] = (req[j] & chan_en[j % BW]) ^ k[j % KW] ^ KP[j % KW];
        return e;
    endfunction

    function automatic int lowest(input logic [N-1:0] v);
        for (int j = 0; j < N; j++) if (v[j]) return j;
        return -1;
    endfunction

    task automatic model_reset();
        m_key = '0; m_cnt = 0; m_loading = 0; m_ready = 0;
        m_gv = 0; m_gb = '0; m_gc = '0;
`ifdef LOCKED_IRQ_STICKY_REQ_EN
        m_pend = '0;
`endif
    endtask

    task automatic model_edge();
        logic [N-1:0] cand;
        logic [3:0]   cm;
        int           w;
        cand = eff_req(m_key);
`ifdef LOCKED_IRQ_STICKY_REQ_EN
        cand = cand | m_pend;
`endif
        if (m_ready) begin
            if (key_load) begin
                m_ready = 0; m_gv = 0; m_loading = 1; m_cnt = 1;
                m_key = {key_sdi, m_key[31:1]};
`ifdef LOCKED_IRQ_STICKY_REQ_EN
                m_pend = '0;
`endif
            end else if (m_gv) begin
                if (grant_ack) m_gv = 0;
`ifdef LOCKED_IRQ_STICKY_REQ_EN
                m_pend = cand;
`endif
            end else begin
                w = lowest(cand);
                if (w >= 0) begin
                    for (int c = 0; c < CW; c++) cm[c] = m_key[31-c] ^ KP[31-c];
                    m_gv = 1;
                    m_gb = 3'(1 << (w / BW));
                    m_gc = 4'(w % BW) ^ cm;
                    cand[w] = 1'b0;
                end
`ifdef LOCKED_IRQ_STICKY_REQ_EN
                m_pend = cand;
`endif
            end
        end else if (m_loading) begin
            if (key_load) begin
                m_key = {key_sdi, m_key[31:1]};
                if (m_cnt < KW) m_cnt++;
            end else begin
                m_loading = 0;
                m_ready = (m_cnt == KW);
                m_cnt = 0;
            end
        end else if (key_load) begin
            m_loading = 1; m_cnt = 1;
            m_key = {key_sdi, m_key[31:1]};
`ifdef LOCKED_IRQ_STICKY_REQ_EN
            m_pend = '0;
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk_all("step");
    endtask

    task automatic do_reset();
        key_load = 0;
        grant_ack = 0;
        #2;
        rst = 1;
        model_reset();
        #1;
        chk_all("reset");
        #2;
        rst = 0;
    endtask

    task automatic load_key(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            key_load = 1;
            key_sdi = bits[i];
            step();
        end
        key_load = 0;
        step();
    endtask

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            req = N'($urandom) & N'($urandom) & N'($urandom);
            chan_en = BW'($urandom);
            grant_ack = 1'($urandom_range(0, 1));
            step();
        end
        req = '0;
        grant_ack = 1;
        step();
        grant_ack = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        load_key(KP, 32);
        chk("load_ready", 32'(key_ready), 1);

        req = '0; req[10] = 1; req[22] = 1; chan_en = '1;
        step();
        chk("prio_valid", 32'(grant_valid), 1);
        chk("prio_bus", 32'(grant_bus), 32'b010);
        chk("prio_chan", 32'(grant_chan), 1);
        req[10] = 0; grant_ack = 1;
        step();
        chk("ack_valid", 32'(grant_valid), 0);
        grant_ack = 0;
        step();
        chk("second_bus", 32'(grant_bus), 32'b100);
        chk("second_chan", 32'(grant_chan), 4);
        req = '0; grant_ack = 1;
        step();
        grant_ack = 0;

        chan_en = 9'h1FE; req = 27'h1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("masked_novalid", 32'(grant_valid), 0);
        end

        random_run(400);

        chan_en = '1; req = 27'h8;
        step();
        chk("hold_valid", 32'(grant_valid), 1);
        req = 27'h20;
        step();
        req = '0;
        step();
        grant_ack = 1;
        step();
        grant_ack = 0;
        step();
`ifdef LOCKED_IRQ_STICKY_REQ_EN
        chk("sticky_valid", 32'(grant_valid), 1);
        chk("sticky_chan", 32'(grant_chan), 5);
`else
        chk("level_lost", 32'(grant_valid), 0);
`endif
        grant_ack = 1;
        step();
        grant_ack = 0; req = 27'h8;
        step();
        chk("abort_pre_valid", 32'(grant_valid), 1);
        req = '0;
        key_load = 1; grant_ack = 1; key_sdi = KP[0];
        step();
        grant_ack = 0;
        chk("abort_valid", 32'(grant_valid), 0);
        chk("abort_ready", 32'(key_ready), 0);
        for (int i = 1; i < 31; i++) begin
            key_sdi = KP[i];
            step();
        end
        key_load = 0;
        step();
        chk("restart_short", 32'(key_ready), 0);
        load_key(KP, 32);
        chk("reload_ready", 32'(key_ready), 1);

        load_key(KP ^ 32'h1, 32);
        req = '0; chan_en = '1;
        step();
        chk("wrong_valid", 32'(grant_valid), 1);
        chk("wrong_bus", 32'(grant_bus), 32'b001);
        chk("wrong_chan", 32'(grant_chan), 0);
        random_run(100);
        load_key(KP ^ 32'h1, 32);
        step();
        do_reset();

        for (int i = 0; i < 10; i++) begin
            key_load = 1;
            key_sdi = KP[i];
            step();
        end
        do_reset();
        load_key(KP, 20);
        chk("partial_ready", 32'(key_ready), 0);
        req = '1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("partial_nogrant", 32'(grant_valid), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
